// File: rtl/facto_job_sequencer.sv
// Bus-master sequencer that runs one FactoCore factorial job per request:
// clear, enable interrupt, load operand, start, await interrupt, read the 128-bit result.
module facto_job_sequencer #(
  parameter logic [15:0] BASE_ADDR   = 16'h7000,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [63:0]   job_operand,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [127:0]  res_data,
  output logic          res_err,
  output logic          busy,
  output logic          s_sel,
  output logic          s_wr,
  output logic [15:0]   s_addr,
  output logic [63:0]   s_din,
  input  logic [63:0]   s_dout,
  input  logic          interrupt
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  localparam logic [15:0] AddrStart = BASE_ADDR + 16'h0000;
  localparam logic [15:0] AddrClear = BASE_ADDR + 16'h0008;
  localparam logic [15:0] AddrIntEn = BASE_ADDR + 16'h0018;
  localparam logic [15:0] AddrOpnd  = BASE_ADDR + 16'h0020;
  localparam logic [15:0] AddrResH  = BASE_ADDR + 16'h0028;
  localparam logic [15:0] AddrResL  = BASE_ADDR + 16'h0030;

  typedef enum logic [3:0] {
    StIdle, StClrSet, StClrRel, StWrIen, StWrOpnd, StWrStart,
    StWaitInt, StRdH, StRdL, StAbort, StResp
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     operand_q, operand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            job_ready_q, job_ready_d;
  logic            res_valid_q, res_valid_d;
  logic [127:0]    res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic            s_sel_q, s_sel_d;
  logic            s_wr_q, s_wr_d;
  logic [15:0]     s_addr_q, s_addr_d;
  logic [63:0]     s_din_q, s_din_d;

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;

    unique case (state_q)
      StIdle: begin
        if (job_valid && job_ready_q) begin
          operand_d = job_operand;
          state_d   = StClrSet;
        end
      end
      StClrSet:  state_d = StClrRel;
      StClrRel:  state_d = StWrIen;
      StWrIen:   state_d = StWrOpnd;
      StWrOpnd:  state_d = StWrStart;
      StWrStart: begin
        cnt_d   = '0;
        state_d = StWaitInt;
      end
      StWaitInt: begin
        // Interrupt takes priority over a timeout landing in the same cycle.
        if (interrupt) begin
          state_d = StRdH;
        end else if (cnt_q == CntLast) begin
          state_d = StAbort;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdH: begin
        res_data_d[127:64] = s_dout;
        state_d            = StRdL;
      end
      StRdL: begin
        res_data_d[63:0] = s_dout;
        state_d          = StResp;
      end
      StAbort: begin
        res_data_d = '0;
        res_err_d  = 1'b1;
        state_d    = StResp;
      end
      StResp: begin
        if (res_ready) begin
          res_err_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus outputs are registered and decoded from the upcoming state, so each
    // access is presented for exactly the cycle its state is resident.
    s_sel_d  = 1'b0;
    s_wr_d   = 1'b0;
    s_addr_d = '0;
    s_din_d  = '0;
    unique case (state_d)
      StClrSet:  begin s_sel_d = 1'b1; s_wr_d = 1'b1; s_addr_d = AddrClear; s_din_d = 64'd1; end
      StClrRel:  begin s_sel_d = 1'b1; s_wr_d = 1'b1; s_addr_d = AddrClear; s_din_d = 64'd0; end
      StWrIen:   begin s_sel_d = 1'b1; s_wr_d = 1'b1; s_addr_d = AddrIntEn; s_din_d = 64'd1; end
      StWrOpnd:  begin s_sel_d = 1'b1; s_wr_d = 1'b1; s_addr_d = AddrOpnd;  s_din_d = operand_d; end
      StWrStart: begin s_sel_d = 1'b1; s_wr_d = 1'b1; s_addr_d = AddrStart; s_din_d = 64'd1; end
      StRdH:     begin s_sel_d = 1'b1; s_addr_d = AddrResH; end
      StRdL:     begin s_sel_d = 1'b1; s_addr_d = AddrResL; end
      StAbort:   begin s_sel_d = 1'b1; s_wr_d = 1'b1; s_addr_d = AddrClear; s_din_d = 64'd1; end
      default:   ;
    endcase

    job_ready_d = (state_d == StIdle);
    res_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      operand_q   <= '0;
      cnt_q       <= '0;
      job_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      s_sel_q     <= 1'b0;
      s_wr_q      <= 1'b0;
      s_addr_q    <= '0;
      s_din_q     <= '0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      cnt_q       <= cnt_d;
      job_ready_q <= job_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      s_sel_q     <= s_sel_d;
      s_wr_q      <= s_wr_d;
      s_addr_q    <= s_addr_d;
      s_din_q     <= s_din_d;
    end
  end

  assign job_ready = job_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != StIdle);
  assign s_sel     = s_sel_q;
  assign s_wr      = s_wr_q;
  assign s_addr    = s_addr_q;
  assign s_din     = s_din_q;

endmodule

// File: tb/tb_facto_job_sequencer.sv
// Directed bench for facto_job_sequencer against a small FactoCore stub slave
// that raises its interrupt a few cycles after OPSTART.
module tb_facto_job_sequencer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [63:0]  job_operand = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [127:0] res_data;
  logic         res_err;
  logic         busy;
  logic         s_sel;
  logic         s_wr;
  logic [15:0]  s_addr;
  logic [63:0]  s_din;
  logic [63:0]  s_dout;
  logic         interrupt = 1'b0;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;

  facto_job_sequencer #(
    .BASE_ADDR  (16'h7000),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_operand(job_operand),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .busy       (busy),
    .s_sel      (s_sel),
    .s_wr       (s_wr),
    .s_addr     (s_addr),
    .s_din      (s_din),
    .s_dout     (s_dout),
    .interrupt  (interrupt)
  );

  always #5 clk = ~clk;

  // FactoCore stub
  bit           irq_en = 1'b1;
  logic [63:0]  stub_opnd = '0;
  logic [127:0] stub_res = '0;
  int           pend = 0;
  logic [79:0]  trace[$];

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r = 128'd1;
    for (longint unsigned i = 2; i <= n; i++) r = r * 128'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (s_sel && s_wr) begin
      trace.push_back({s_addr, s_din});
      if (s_addr == 16'h7008 && s_din[0]) begin
        interrupt <= 1'b0;
        pend      <= 0;
      end else if (s_addr == 16'h7020) begin
        stub_opnd <= s_din;
      end else if (s_addr == 16'h7000 && s_din[0]) begin
        stub_res  <= fact(stub_opnd);
        interrupt <= 1'b0;
        pend      <= irq_en ? 3 : 0;
      end
    end else if (pend > 1) begin
      pend <= pend - 1;
    end else if (pend == 1) begin
      pend      <= 0;
      interrupt <= 1'b1;
    end
    if (reset_n && job_valid && job_ready) acc_cnt <= acc_cnt + 1;
  end

  assign s_dout = (s_sel && !s_wr && s_addr == 16'h7028) ? stub_res[127:64] :
                  (s_sel && !s_wr && s_addr == 16'h7030) ? stub_res[63:0]   : 64'd0;

  // Presents a job until accepted; returns at the negedge after the accepting edge.
  task automatic start_job(input logic [63:0] n, output bit ok);
    ok = 1'b0;
    job_operand = n;
    job_valid   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (job_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [213:0] got;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {job_ready, res_valid, res_data, res_err, busy, s_sel, s_wr, s_addr, s_din};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", got);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_ready got ready=%b busy=%b want ready=1 busy=0", job_ready, busy);
    end
  endtask

  task automatic test_basic();
    bit ok_a, ok_r;
    logic [79:0] exp_tr[5];
    exp_tr = '{{16'h7008, 64'd1}, {16'h7008, 64'd0}, {16'h7018, 64'd1},
               {16'h7020, 64'd5}, {16'h7000, 64'd1}};
    trace.delete();
    res_ready = 1'b1;
    start_job(64'd5, ok_a);
    checks++;
    if (busy !== 1'b1 || job_ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_accept got busy=%b ready=%b want 1/0", busy, job_ready);
    end
    wait_res(ok_r);
    checks++;
    if (!(ok_a && ok_r)) begin
      failures++;
      $display("FAIL basic_handshake got accept=%b resp=%b want 1/1", ok_a, ok_r);
    end
    checks++;
    if (res_data !== 128'd120 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_n5 got data=%0d err=%b want 120/0", res_data, res_err);
    end
    checks++;
    if (trace.size() != 5) begin
      failures++;
      $display("FAIL basic_trace_len got %0d want 5", trace.size());
    end
    for (int i = 0; i < 5 && i < trace.size(); i++) begin
      checks++;
      if (trace[i] !== exp_tr[i]) begin
        failures++;
        $display("FAIL basic_trace[%0d] got %h want %h", i, trace[i], exp_tr[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_release got valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_values();
    bit ok_a, ok_r;
    logic [63:0]  ops[3];
    logic [127:0] exps[3];
    ops  = '{64'd10, 64'd0, 64'd1};
    exps = '{128'd3628800, 128'd1, 128'd1};
    for (int k = 0; k < 3; k++) begin
      start_job(ops[k], ok_a);
      wait_res(ok_r);
      checks++;
      if (!(ok_a && ok_r) || res_data !== exps[k] || res_err !== 1'b0) begin
        failures++;
        $display("FAIL value_n%0d got data=%0d err=%b ok=%b%b want %0d/0",
                 ops[k], res_data, res_err, ok_a, ok_r, exps[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit ok_a, ok_r;
    int a0;
    res_ready = 1'b0;
    start_job(64'd5, ok_a);
    a0 = acc_cnt;
    job_operand = 64'd9;
    job_valid   = 1'b1;
    wait_res(ok_r);
    checks++;
    if (!(ok_a && ok_r)) begin
      failures++;
      $display("FAIL bp_handshake got accept=%b resp=%b want 1/1", ok_a, ok_r);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 128'd120 || job_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%0d ready=%b want 1/120/0",
                 i, res_valid, res_data, job_ready);
      end
      @(negedge clk);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || acc_cnt != a0) begin
      failures++;
      $display("FAIL bp_release got valid=%b extra_accepts=%0d want 0/0", res_valid, acc_cnt - a0);
    end
  endtask

  task automatic test_timeout();
    bit ok_a, ok_r;
    irq_en = 1'b0;
    trace.delete();
    start_job(64'd5, ok_a);
    wait_res(ok_r);
    checks++;
    if (!(ok_a && ok_r) || res_err !== 1'b1 || res_data !== '0) begin
      failures++;
      $display("FAIL timeout_resp got err=%b data=%0d ok=%b%b want 1/0", res_err, res_data, ok_a, ok_r);
    end
    checks++;
    if (trace.size() != 6 || trace[trace.size()-1] !== {16'h7008, 64'd1}) begin
      failures++;
      $display("FAIL timeout_abort_write got len=%0d want len=6 last=7008/1", trace.size());
    end
    @(negedge clk);
    checks++;
    if (res_err !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got err=%b valid=%b want 0/0", res_err, res_valid);
    end
    irq_en = 1'b1;
  endtask

  task automatic test_reset_midjob();
    bit ok_a, ok_r;
    logic [213:0] got;
    trace.delete();
    start_job(64'd7, ok_a);
    for (int i = 0; i < 20 && trace.size() < 5; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || s_sel !== 1'b0) begin
      failures++;
      $display("FAIL midjob_waitint got busy=%b sel=%b want 1/0", busy, s_sel);
    end
    reset_n = 1'b0;
    @(negedge clk);
    got = {job_ready, res_valid, res_data, res_err, busy, s_sel, s_wr, s_addr, s_din};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL midjob_reset got=%h want=0", got);
    end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midjob_silent got valid=%b busy=%b want 0/0", res_valid, busy);
    end
    start_job(64'd3, ok_a);
    wait_res(ok_r);
    checks++;
    if (!(ok_a && ok_r) || res_data !== 128'd6 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL midjob_next_n3 got data=%0d err=%b want 6/0", res_data, res_err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok_r;
    int a0;
    a0 = acc_cnt;
    res_ready   = 1'b0;
    job_operand = 64'd4;
    job_valid   = 1'b1;
    @(negedge clk);
    job_operand = 64'd6;
    wait_res(ok_r);
    checks++;
    if (!ok_r || res_data !== 128'd24) begin
      failures++;
      $display("FAIL b2b_first got data=%0d ok=%b want 24", res_data, ok_r);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (job_ready !== 1'b0 || acc_cnt - a0 != 1) begin
      failures++;
      $display("FAIL b2b_hold got ready=%b accepts=%0d want 0/1", job_ready, acc_cnt - a0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (job_ready !== 1'b1 || acc_cnt - a0 != 1) begin
      failures++;
      $display("FAIL b2b_reopen got ready=%b accepts=%0d want 1/1", job_ready, acc_cnt - a0);
    end
    @(negedge clk);
    job_valid = 1'b0;
    wait_res(ok_r);
    checks++;
    if (!ok_r || res_data !== 128'd720 || acc_cnt - a0 != 2) begin
      failures++;
      $display("FAIL b2b_second got data=%0d accepts=%0d want 720/2", res_data, acc_cnt - a0);
    end
    res_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_backpressure();
    test_timeout();
    test_reset_midjob();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
